// File: rtl/data_mem_responder_if.sv
// Memory-stage request/response bundle between the pipeline and the data memory responder.
interface data_mem_responder_if #(
  parameter int W  = 16,
  parameter int AW = 11
);
  logic          memRead;
  logic          memWrite;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata;
  logic [W-1:0]  RD;
  logic          rdValid;
  logic          stall;
  logic          err;

  modport master (
    output memRead, memWrite, addr, wdata,
    input  RD, rdValid, stall, err
  );

  modport slave (
    input  memRead, memWrite, addr, wdata,
    output RD, rdValid, stall, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: captures one request, waits LAT cycles in BUSY,
// performs the array access, then spends one DONE cycle releasing the pipeline.
module data_mem_responder #(
  parameter int W     = 16,
  parameter int AW    = 11,
  parameter int DEPTH = 2048,
  parameter int LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_responder_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (LAT < 1 || LAT > 15) begin : g_bad_lat
      $error("data_mem_responder: LAT must be in 1..15");
    end
    if (DEPTH > (1 << AW)) begin : g_bad_depth
      $error("data_mem_responder: DEPTH exceeds address space");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } req_t;

  state_t        state;
  logic [3:0]    cnt;
  req_t          cap;
  logic [W-1:0]  rd_q;
  logic          rdv_q;
  logic          err_q;
  logic [W-1:0]  mem [DEPTH];

  logic          req;
  logic          in_rng;
  logic          fire;
  logic [IW-1:0] idx;

  assign req    = bus.memRead | bus.memWrite;
  assign in_rng = {1'b0, cap.addr} < (AW+1)'(DEPTH);
  assign idx    = cap.addr[IW-1:0];
  assign fire   = (state == BUSY) && (cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      cap   <= '0;
      rd_q  <= '0;
      rdv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rdv_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: if (req) begin
          cap.wr   <= bus.memWrite;
          cap.addr <= bus.addr;
          cap.data <= bus.wdata;
          cnt      <= 4'(LAT - 1);
          state    <= BUSY;
        end
        BUSY: if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          state <= DONE;
          err_q <= !in_rng;
          if (!cap.wr) begin
            // out-of-range loads still complete, returning zero
            rd_q  <= in_rng ? mem[idx] : '0;
            rdv_q <= 1'b1;
          end
        end
        // frozen stage still presents its request here; ignore it
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // array has no reset; a reset mid-access forces IDLE so fire never reaches here
  always_ff @(posedge clk) begin
    if (fire && cap.wr && in_rng)
      mem[idx] <= cap.data;
  end

  assign bus.RD      = rd_q;
  assign bus.rdValid = rdv_q;
  assign bus.err     = err_q;
  assign bus.stall   = ((state == IDLE) && req && !rst) || (state == BUSY);
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: main instance (DEPTH=1024, LAT=2) plus LAT=1/15 builds.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite;
  logic [10:0] addr;
  logic [15:0] wdata;
  int          n_run = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  data_mem_responder_if #(.W(16), .AW(11)) m0 ();
  data_mem_responder_if #(.W(16), .AW(11)) m1 ();
  data_mem_responder_if #(.W(16), .AW(11)) m15 ();

  assign m0.memRead  = memRead;  assign m0.memWrite  = memWrite;
  assign m0.addr     = addr;     assign m0.wdata     = wdata;
  assign m1.memRead  = memRead;  assign m1.memWrite  = memWrite;
  assign m1.addr     = addr;     assign m1.wdata     = wdata;
  assign m15.memRead = memRead;  assign m15.memWrite = memWrite;
  assign m15.addr    = addr;     assign m15.wdata    = wdata;

  data_mem_responder #(.W(16), .AW(11), .DEPTH(1024), .LAT(2))  u0  (.clk(clk), .rst(rst), .bus(m0));
  data_mem_responder #(.W(16), .AW(11), .DEPTH(2048), .LAT(1))  u1  (.clk(clk), .rst(rst), .bus(m1));
  data_mem_responder #(.W(16), .AW(11), .DEPTH(2048), .LAT(15)) u15 (.clk(clk), .rst(rst), .bus(m15));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request on the main instance (called just after a rising edge) and
  // hold it until the DONE cycle has ended, as a frozen stage would.
  task automatic do_op(input logic w, input logic r, input logic [10:0] a, input logic [15:0] d,
                       output int ns, output logic v, output logic e, output logic [15:0] rd);
    bit done = 0;
    memWrite = w; memRead = r; addr = a; wdata = d;
    ns = 0; v = 1'bx; e = 1'bx; rd = 'x;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (m0.stall) ns++;
      else begin
        v = m0.rdValid; e = m0.err; rd = m0.RD; done = 1;
      end
      @(posedge clk); #1;
    end
    memRead = 1'b0; memWrite = 1'b0;
    if (!done) chk("op_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int          ns;
    logic        v, e;
    logic [15:0] rd;
    logic [7:0]  st, rv;
    int          c0n, c1n, c15n, c0v, c1v, c15v;

    rst = 1'b1; memRead = 1'b1; memWrite = 1'b0; addr = '0; wdata = '0;
    #3;
    chk("rst_stall",   m0.stall,   0);
    chk("rst_rd",      m0.RD,      0);
    chk("rst_rdvalid", m0.rdValid, 0);
    chk("rst_err",     m0.err,     0);
    memRead = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // store then load
    do_op(1, 0, 11'h005, 16'hBEEF, ns, v, e, rd);
    chk("wr_stall_cycles", ns, 3);
    chk("wr_rdvalid", v, 0);
    chk("wr_err", e, 0);
    do_op(0, 1, 11'h005, 16'h0000, ns, v, e, rd);
    chk("rd_stall_cycles", ns, 3);
    chk("rd_rdvalid", v, 1);
    chk("rd_data", rd, 16'hBEEF);
    chk("rd_err", e, 0);

    // both strobes: write wins, RD untouched
    do_op(1, 1, 11'h010, 16'h1234, ns, v, e, rd);
    chk("both_rdvalid", v, 0);
    chk("both_rd_kept", rd, 16'hBEEF);
    do_op(0, 1, 11'h010, 16'h0000, ns, v, e, rd);
    chk("both_readback", rd, 16'h1234);

    // request held continuously: one access per LAT+2 cycles
    memRead = 1'b1; addr = 11'h005;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      st[i] = m0.stall; rv[i] = m0.rdValid;
      @(posedge clk); #1;
    end
    memRead = 1'b0;
    chk("held_stall_pattern", st, 8'h77);
    chk("held_rdvalid_pattern", rv, 8'h88);

    // out-of-range accesses (DEPTH=1024)
    do_op(1, 0, 11'h000, 16'h0A0A, ns, v, e, rd);
    do_op(0, 1, 11'h400, 16'h0000, ns, v, e, rd);
    chk("oob_rd_data", rd, 0);
    chk("oob_rd_rdvalid", v, 1);
    chk("oob_rd_err", e, 1);
    do_op(1, 0, 11'h400, 16'h5555, ns, v, e, rd);
    chk("oob_wr_err", e, 1);
    chk("oob_wr_rdvalid", v, 0);
    do_op(0, 1, 11'h000, 16'h0000, ns, v, e, rd);
    chk("oob_no_alias", rd, 16'h0A0A);
    chk("inrange_err", e, 0);

    // reset during BUSY of a write drops it
    do_op(1, 0, 11'h020, 16'h1111, ns, v, e, rd);
    memWrite = 1'b1; addr = 11'h020; wdata = 16'hAAAA;
    @(negedge clk);
    @(posedge clk); #2;
    chk("busy_stall", m0.stall, 1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", m0.stall, 0);
    chk("midrst_rd", m0.RD, 0);
    chk("midrst_rdvalid", m0.rdValid, 0);
    memWrite = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(0, 1, 11'h020, 16'h0000, ns, v, e, rd);
    chk("midrst_write_dropped", rd, 16'h1111);

    // latency builds: one-cycle request seen by all three instances
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    c0n = 0; c1n = 0; c15n = 0; c0v = -1; c1v = -1; c15v = -1;
    memRead = 1'b1; addr = 11'h005;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0.stall)  c0n++;
      if (m1.stall)  c1n++;
      if (m15.stall) c15n++;
      if (m0.rdValid)  c0v = i;
      if (m1.rdValid)  c1v = i;
      if (m15.rdValid) c15v = i;
      @(posedge clk); #1;
      if (i == 0) memRead = 1'b0;
    end
    chk("lat2_stall_cycles", c0n, 3);
    chk("lat2_rdvalid_cycle", c0v, 3);
    chk("lat1_stall_cycles", c1n, 2);
    chk("lat1_rdvalid_cycle", c1v, 2);
    chk("lat15_stall_cycles", c15n, 16);
    chk("lat15_rdvalid_cycle", c15v, 16);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder for the Memory stage of the five-stage pipeline. It accepts the read/write requests the Memory stage issues (`memRead`, `memWrite`, 11-bit address, 16-bit store data) and serves them from an internal word array after a fixed wait latency. While a request is in flight it holds the pipeline with `stall`, and it returns load data with a one-cycle `rdValid` strobe.

## Interface
- `W`, 16, data word width
- `AW`, 11, address width
- `DEPTH`, 2048, implemented words; must satisfy DEPTH ≤ 2^AW
- `LAT`, 2, wait cycles spent in BUSY; legal range 1..15
- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-high
- `memRead`  in  1  load request
- `memWrite`  in  1  store request; wins if asserted together with `memRead`
- `addr`  in  AW  word address
- `wdata`  in  W  store data
- `RD`  out  W  load data, registered
- `rdValid`  out  1  one-cycle strobe: `RD` holds a fresh load result
- `stall`  out  1  freeze the pipeline; combinational
- `err`  out  1  one-cycle strobe: the completed request had `addr` ≥ DEPTH

## Operation
- FSM states:
  - IDLE: accepts requests.
  - BUSY: counts wait cycles.
  - DONE: a one-cycle release state.
- A request is present when `memRead | memWrite` is high.
- IDLE → BUSY on the first edge with a request present:
  - capture `addr`, `wdata` and the op into internal registers; op = write if `memWrite` is high, else read;
  - load the counter with LAT-1.
- BUSY, counter > 0: decrement the counter each edge.
- BUSY, counter == 0: perform the access on that edge, then go to DONE.
  - Write, captured addr < DEPTH: the array word is updated with the captured data.
  - Read, captured addr < DEPTH: `RD` ← array[addr] and `rdValid` ← 1.
  - Captured addr ≥ DEPTH: no array update. A read loads `RD` ← 0 with `rdValid` ← 1. `err` ← 1 for both ops.
- DONE → IDLE unconditionally. Request inputs are ignored in DONE, because the frozen stage still presents the same request.
- `stall` = (IDLE & request present & !rst) | BUSY. It is 0 in DONE.
- `rdValid` and `err` are high only in the DONE cycle. They are never high for a write, except `err`.
- `RD` holds its value until the next read completes. Writes do not change `RD`.
- Array contents are not cleared by reset. Only the control state and the outputs are reset.

## Timing
- Reset values (asynchronous):
  - state = IDLE, counter = 0;
  - `RD` = 0, `rdValid` = 0, `err` = 0;
  - `stall` = 0 while `rst` is high.
- Let c0 be the first IDLE cycle with a request present.
  - `stall` is high in c0 through c(LAT), i.e. LAT+1 cycles.
  - DONE is cycle c(LAT+1): `stall` = 0, plus `rdValid`/`err` where applicable.
  - The pipeline advances on the edge ending c(LAT+1).
- A new request is accepted no earlier than c(LAT+2). Back-to-back loads/stores therefore cost LAT+2 cycles each.
- A write becomes visible to a read accepted at any later IDLE cycle; there is no bypass needed.
- Reset mid-operation (BUSY or DONE):
  - immediate return to IDLE and outputs cleared;
  - a pending write is dropped, leaving the array word unchanged;
  - a pending read produces no `rdValid`.
- Request inputs changing during BUSY have no effect, since the captured values are used.

## Test plan
- Reset, then write `addr`=0x005, `wdata`=0xBEEF (LAT=2) -> `stall` high 3 cycles, then low; `rdValid`=0 and `err`=0 in DONE. A following read of 0x005 -> `rdValid` pulse with `RD`=0xBEEF in the 4th cycle after its request first appears.
- `memRead` and `memWrite` both high, `addr`=0x010, `wdata`=0x1234 -> treated as a write; a later read of 0x010 returns 0x1234 and the intermediate `RD` is unchanged.
- Request held high through DONE (frozen stage) -> exactly one access and one `rdValid` pulse; a fresh request at c(LAT+2) is accepted.
- DEPTH=1024, read `addr`=0x400 -> `RD`=0, `rdValid`=1, `err`=1 in DONE. A write to 0x400 -> `err`=1 and no aliasing: word 0x000 is unchanged.
- Assert `rst` during BUSY of a write 0xAAAA to 0x020 -> outputs 0 immediately, `stall`=0; after reset a read of 0x020 returns the old value, not 0xAAAA.
- LAT=1 and LAT=15 builds -> `stall` width 2 and 16 cycles respectively; `rdValid` in c2 and c16.
